root_accel: RTL and testbench
=============================

ROOT_ACCEL -- requirements
Module: root_accel

Interface
REQ-001 SHALL have parameter W, default 8, legal range 4..16: operand width of a_bi and b_bi.
REQ-002 SHALL derive localparam CW = ceil(W/3) (cube-root width), XW = W+1 (sum width), YW = ceil(XW/2) (result width).
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  request; sampled only in IDLE.
REQ-006 a_bi  input  W  addend operand.
REQ-007 b_bi  input  W  cube-root operand.
REQ-008 busy_o  output  1  high while an operation is in flight.
REQ-009 valid_o  output  1  one-cycle pulse when y_bo is updated.
REQ-010 y_bo  output  YW  result floor(sqrt(a + floor(cbrt(b)))).

Function
REQ-011 SHALL latch a_bi, b_bi into internal registers on the edge where state=IDLE and start_i=1; later operand changes have no effect.
REQ-012 SHALL implement states IDLE, CB_SQ, CB_CUBE, CB_CMP, ADD, SQ_INIT, SQ_STEP, DONE.
REQ-013 IDLE->CB_SQ on start_i; otherwise stay IDLE.
REQ-014 Cube root by digit-by-digit search, bit i from CW-1 down to 0: candidate c = r | (1<<i); CB_SQ computes c*c, CB_CUBE computes (c*c)*c via the multiplier, each waiting until multiplier busy is low; CB_CMP sets r=c iff c*c*c <= b; next bit or ADD after bit 0.
REQ-015 Cube product SHALL be computed at 3*CW bits without truncation.
REQ-016 ADD: x = a + r at XW bits, no overflow possible.
REQ-017 SQ_INIT/SQ_STEP: restoring bit-pair square root on x, one result bit per SQ_STEP cycle, exactly YW SQ_STEP cycles.
REQ-018 DONE: y_bo <= root, valid_o=1 for exactly this one cycle, then ->IDLE.
REQ-019 busy_o SHALL be 1 in every state except IDLE; busy_o is 0 in the cycle valid_o is 1? No: busy_o=1 in DONE, 0 from the following cycle.
REQ-020 start_i while busy_o=1 SHALL be ignored (no queuing, no operand capture).
REQ-021 y_bo SHALL hold its last value between operations.
REQ-022 b=0 SHALL yield r=0; a=b=0 SHALL yield y_bo=0.

Reset
REQ-023 rst_i=1 SHALL force state=IDLE, busy_o=0, valid_o=0, y_bo=0, clear operand/working registers and reset the multiplier, in any state including mid-operation; no valid_o pulse for the aborted operation.
REQ-024 start_i in the same cycle as rst_i SHALL be ignored.

Configuration
REQ-025 Macro ROOT_ACCEL_CYCLES_EN defined: SHALL add output cycles_bo (16 bits), counting cycles from the start-capture edge up to and including DONE, loaded when valid_o pulses, saturating at 16'hFFFF, reset to 0.
REQ-026 Macro undefined: cycles_bo port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-027 Shared package SHALL hold the state encoding (3-bit) and width-derivation functions (ceil-div helpers for CW, YW).
REQ-028 One sub-module, mult_seq: parametrised shift-add multiplier (clk_i, rst_i start, a_bi, b_bi, busy_o, y_bo), result valid when busy_o falls, latency = width of b_bi + 1 cycles.
REQ-029 Add/compare/sqrt datapath SHALL stay inline in root_accel.

Verification
REQ-030 W=8, a=13, b=27, start pulse -> one valid_o pulse, y_bo=4; busy_o low after.
REQ-031 W=8, a=255, b=255 -> cbrt=6, sum=261, y_bo=16.
REQ-032 W=8, a=0, b=0 -> y_bo=0; then a=0, b=27 -> y_bo=1 (sqrt 3).
REQ-033 start_i held high with new operands during busy -> result equals first operands only, exactly one valid_o per accepted start.
REQ-034 rst_i asserted mid CB_CUBE -> next cycle busy_o=0, y_bo=0, no valid_o; fresh start a=13, b=27 -> y_bo=4.
REQ-035 W=12, a=4095, b=4095 -> cbrt=15, sum=4110, y_bo=64; with ROOT_ACCEL_CYCLES_EN, cycles_bo equals bench-counted start-to-DONE cycles.

Source files
------------

// File: rtl/root_accel_pkg.sv
// Shared definitions for root_accel: FSM state encoding and width-derivation helpers.
package root_accel_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CB_SQ   = 3'd1,
        CB_CUBE = 3'd2,
        CB_CMP  = 3'd3,
        ADD     = 3'd4,
        SQ_INIT = 3'd5,
        SQ_STEP = 3'd6,
        DONE    = 3'd7
    } state_e;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/root_accel_mult_seq.sv
// Sequential shift-add multiplier: busy for BW+1 cycles after start, product valid when busy falls.
module mult_seq #(
    parameter int AW = 6,
    parameter int BW = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [AW-1:0]    a_bi,
    input  logic [BW-1:0]    b_bi,
    output logic             busy_o,
    output logic [AW+BW-1:0] y_bo
);
    localparam int CNTW = $clog2(BW + 1);

    logic [AW+BW-1:0] acc_q;
    logic [AW+BW-1:0] a_q;
    logic [BW-1:0]    b_q;
    logic [CNTW-1:0]  cnt_q;
    logic             busy_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (!busy_q) begin
            if (start_i) begin
                acc_q  <= '0;
                a_q    <= (AW+BW)'(a_bi);
                b_q    <= b_bi;
                cnt_q  <= CNTW'(BW);
                busy_q <= 1'b1;
            end
        end else if (cnt_q != '0) begin
            if (b_q[0]) acc_q <= acc_q + a_q;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q - 1'b1;
        end else begin
            busy_q <= 1'b0;
        end
    end

    assign busy_o = busy_q;
    assign y_bo   = acc_q;

endmodule

// File: rtl/root_accel.sv
// root_accel: y = floor(sqrt(a + floor(cbrt(b)))), multi-cycle FSM with a shared sequential multiplier.
// Define ROOT_ACCEL_CYCLES_EN to add the cycles_bo per-operation cycle counter output.
module root_accel
    import root_accel_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   start_i,
    input  logic [W-1:0]                           a_bi,
    input  logic [W-1:0]                           b_bi,
    output logic                                   busy_o,
    output logic                                   valid_o,
    output logic [root_accel_pkg::ceil_div(W+1,2)-1:0] y_bo
`ifdef ROOT_ACCEL_CYCLES_EN
    ,
    output logic [15:0]                            cycles_bo
`endif
);
    localparam int CW   = ceil_div(W, 3);
    localparam int XW   = W + 1;
    localparam int YW   = ceil_div(XW, 2);
    localparam int SW   = 2 * CW;
    localparam int PW   = 3 * CW;
    localparam int REMW = YW + 3;
    localparam int BITW = $clog2(CW);
    localparam int STW  = $clog2(YW);

    state_e           state_q;
    logic [W-1:0]     a_q, b_q;
    logic [CW-1:0]    r_q;
    logic [BITW-1:0]  bit_q;
    logic [SW-1:0]    sq_q;
    logic [PW-1:0]    cube_q;
    logic [XW-1:0]    x_q;
    logic [2*YW-1:0]  xs_q;
    logic [REMW-1:0]  rem_q;
    logic [YW-1:0]    root_q, y_q;
    logic [STW-1:0]   step_q;
    logic             mul_start_q, mul_run_q, valid_q;

    logic [CW-1:0]    cand;
    logic [SW-1:0]    mul_a;
    logic [PW-1:0]    mul_y;
    logic             mul_busy;
    logic [REMW-1:0]  rem_sh, trial, rem_d;
    logic [YW-1:0]    root_d;
    logic             ge;

    assign cand  = r_q | (CW'(1) << bit_q);
    assign mul_a = (state_q == CB_CUBE) ? sq_q : SW'(cand);

    mult_seq #(.AW(SW), .BW(CW)) u_mult (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(mul_start_q),
        .a_bi   (mul_a),
        .b_bi   (cand),
        .busy_o (mul_busy),
        .y_bo   (mul_y)
    );

    // Restoring square root: bring down the next bit pair, try subtracting 4*root+1.
    assign rem_sh = {rem_q[REMW-3:0], xs_q[2*YW-1 -: 2]};
    assign trial  = REMW'({root_q, 2'b01});
    assign ge     = (rem_sh >= trial);
    assign rem_d  = ge ? (rem_sh - trial) : rem_sh;
    assign root_d = {root_q[YW-2:0], ge};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            bit_q       <= '0;
            sq_q        <= '0;
            cube_q      <= '0;
            x_q         <= '0;
            xs_q        <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            y_q         <= '0;
            step_q      <= '0;
            mul_start_q <= 1'b0;
            mul_run_q   <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    a_q       <= a_bi;
                    b_q       <= b_bi;
                    r_q       <= '0;
                    bit_q     <= BITW'(CW - 1);
                    mul_run_q <= 1'b0;
                    state_q   <= CB_SQ;
                end
                CB_SQ, CB_CUBE: begin
                    // Launch once, give the multiplier a cycle to raise busy, then wait for it to drop.
                    if (!mul_run_q) begin
                        mul_start_q <= 1'b1;
                        mul_run_q   <= 1'b1;
                    end else if (mul_start_q) begin
                        mul_start_q <= 1'b0;
                    end else if (!mul_busy) begin
                        mul_run_q <= 1'b0;
                        if (state_q == CB_SQ) begin
                            sq_q    <= mul_y[SW-1:0];
                            state_q <= CB_CUBE;
                        end else begin
                            cube_q  <= mul_y;
                            state_q <= CB_CMP;
                        end
                    end
                end
                CB_CMP: begin
                    if (cube_q <= PW'(b_q)) r_q <= cand;
                    if (bit_q == '0) begin
                        state_q <= ADD;
                    end else begin
                        bit_q   <= bit_q - 1'b1;
                        state_q <= CB_SQ;
                    end
                end
                ADD: begin
                    x_q     <= XW'(a_q) + XW'(r_q);
                    state_q <= SQ_INIT;
                end
                SQ_INIT: begin
                    xs_q    <= (2*YW)'(x_q);
                    rem_q   <= '0;
                    root_q  <= '0;
                    step_q  <= STW'(YW - 1);
                    state_q <= SQ_STEP;
                end
                SQ_STEP: begin
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    xs_q   <= xs_q << 2;
                    if (step_q == '0) begin
                        y_q     <= root_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        step_q <= step_q - 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign valid_o = valid_q;
    assign y_bo    = y_q;

`ifdef ROOT_ACCEL_CYCLES_EN
    // cnt_q holds the index of the current busy cycle; the total includes the DONE cycle.
    logic [15:0] cnt_q, cycles_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            if (state_q == IDLE && start_i) cnt_q <= 16'd1;
            else if (state_q != IDLE)       cnt_q <= sat_inc16(cnt_q);
            if (state_q == SQ_STEP && step_q == '0) cycles_q <= sat_inc16(cnt_q);
        end
    end

    assign cycles_bo = cycles_q;
`endif

endmodule

// File: tb/tb_root_accel.sv
// Directed bench for root_accel: W=8 and W=12 instances, vector table plus reset/held-start sequences.
module tb_root_accel;
    import root_accel_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start12;
    logic [7:0]  a8, b8;
    logic [11:0] a12, b12;
    logic        busy8, valid8, busy12, valid12;
    logic [4:0]  y8;
    logic [6:0]  y12;
`ifdef ROOT_ACCEL_CYCLES_EN
    logic [15:0] cycles8, cycles12;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    root_accel #(.W(8)) u8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_bi(a8), .b_bi(b8),
        .busy_o(busy8), .valid_o(valid8), .y_bo(y8)
`ifdef ROOT_ACCEL_CYCLES_EN
        , .cycles_bo(cycles8)
`endif
    );

    root_accel #(.W(12)) u12 (
        .clk_i(clk), .rst_i(rst), .start_i(start12), .a_bi(a12), .b_bi(b12),
        .busy_o(busy12), .valid_o(valid12), .y_bo(y12)
`ifdef ROOT_ACCEL_CYCLES_EN
        , .cycles_bo(cycles12)
`endif
    );

    typedef struct {
        int    a;
        int    b;
        int    exp_y;
        string name;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int get_busy(input int sel);
        return (sel == 0) ? int'(busy8) : int'(busy12);
    endfunction
    function automatic int get_valid(input int sel);
        return (sel == 0) ? int'(valid8) : int'(valid12);
    endfunction
    function automatic int get_y(input int sel);
        return (sel == 0) ? int'(y8) : int'(y12);
    endfunction

    // One start pulse, then follow the operation to idle counting busy cycles and valid pulses.
    task automatic run(input int sel, input int a, input int b, input int exp, input string nm);
        int seen, bc, yv;
        @(negedge clk);
        if (sel == 0) begin a8 = 8'(a); b8 = 8'(b); start8 = 1'b1; end
        else begin a12 = 12'(a); b12 = 12'(b); start12 = 1'b1; end
        @(negedge clk);
        start8 = 1'b0; start12 = 1'b0;
        seen = 0; bc = 0; yv = -1;
        for (int k = 0; k < 3000; k++) begin
            if (get_busy(sel) == 0) break;
            bc++;
            if (get_valid(sel) != 0) begin
                seen++;
                yv = get_y(sel);
            end
            @(negedge clk);
        end
        chk({nm, " valid pulses"}, seen, 1);
        chk({nm, " y at valid"}, yv, exp);
        chk({nm, " idle after"}, get_busy(sel), 0);
        chk({nm, " y held"}, get_y(sel), exp);
`ifdef ROOT_ACCEL_CYCLES_EN
        chk({nm, " cycles"}, (sel == 0) ? int'(cycles8) : int'(cycles12), bc);
`endif
        $display("op %s: a=%0d b=%0d y=%0d busy_cycles=%0d", nm, a, b, yv, bc);
    endtask

    vec_t vecs8[7];

    initial begin
        int seen, extra, yv, found;
        vecs8[0] = '{13, 27, 4, "a13_b27"};
        vecs8[1] = '{255, 255, 16, "a255_b255"};
        vecs8[2] = '{0, 0, 0, "a0_b0"};
        vecs8[3] = '{0, 27, 1, "a0_b27"};
        vecs8[4] = '{100, 8, 10, "a100_b8"};
        vecs8[5] = '{3, 64, 2, "a3_b64"};
        vecs8[6] = '{200, 125, 14, "a200_b125"};

        rst = 1'b1; start8 = 1'b0; start12 = 1'b0;
        a8 = '0; b8 = '0; a12 = '0; b12 = '0;
        repeat (3) @(negedge clk);
        chk("reset busy8", int'(busy8), 0);
        chk("reset valid8", int'(valid8), 0);
        chk("reset y8", int'(y8), 0);
        chk("reset busy12", int'(busy12), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run(0, vecs8[i].a, vecs8[i].b, vecs8[i].exp_y, vecs8[i].name);

        repeat (5) @(negedge clk);
        chk("hold y8 between ops", int'(y8), 14);

        // start held high with changing operands: only the first capture counts
        @(negedge clk);
        a8 = 8'd13; b8 = 8'd27; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd255;
        seen = 0; yv = -1;
        for (int k = 0; k < 3000; k++) begin
            if (valid8) begin seen++; yv = int'(y8); start8 = 1'b0; end
            if (!busy8 && seen > 0) break;
            @(negedge clk);
        end
        start8 = 1'b0;
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            if (valid8 || busy8) extra++;
            @(negedge clk);
        end
        chk("held start valid pulses", seen, 1);
        chk("held start y", yv, 4);
        chk("held start no requeue", extra, 0);
        $display("op held_start: y=%0d pulses=%0d", yv, seen);

        // reset in the middle of the cube multiply
        @(negedge clk);
        a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        found = 0;
        for (int k = 0; k < 500; k++) begin
            if (u8.state_q == CB_CUBE) begin found = 1; break; end
            if (valid8) break;
            @(negedge clk);
        end
        chk("reached CB_CUBE", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy8", int'(busy8), 0);
        chk("abort y8", int'(y8), 0);
        chk("abort valid8", int'(valid8), 0);
        start8 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        @(negedge clk);
        chk("start with reset ignored", int'(busy8), 0);
        chk("no valid after abort", int'(valid8), 0);
        $display("op abort: busy=%0d y=%0d", busy8, y8);

        run(0, 13, 27, 4, "fresh_a13_b27");
        run(1, 4095, 4095, 64, "w12_a4095_b4095");
        run(1, 100, 1000, 10, "w12_a100_b1000");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
